mod16_seq_checker: RTL and testbench

MOD16_SEQ_CHECKER -- requirements
Module: mod16_seq_checker

---
 rtl/mod16_seq_checker_pkg.sv | 14 +
 rtl/mod16_wrap_detect.sv | 33 +++
 rtl/mod16_seq_checker.sv | 113 +++++++++++
 tb/tb_mod16_seq_checker.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod16_seq_checker_pkg.sv
// Shared definitions for the MOD-16 sequence checker: FSM state type and
// width/limit constants used by the top level and the wrap detector.
package mod16_seq_checker_pkg;

  localparam int CNT_W       = 4;
  localparam int ERR_CNT_MAX = 255;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LOCK = 2'd1,
    ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/mod16_wrap_detect.sv
// Previous-sample register plus increment compare and 15->0 wrap detect.
// match/wrap are combinational strobes qualified by the caller with count_vld.
module mod16_wrap_detect
  import mod16_seq_checker_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count,
  input  logic             count_vld,
  output logic             match,
  output logic             wrap
);

  logic [CNT_W-1:0] prev;
  logic [CNT_W-1:0] expected;

  // Track the last valid sample; gaps hold the value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= '0;
    end else if (count_vld) begin
      prev <= count;
    end
  end

  // 4-bit wrapping increment compare; a wrap is a correct 15->0 step.
  always_comb begin
    expected = prev + 1'b1;
    match    = (count == expected);
    wrap     = match && (count == '0);
  end

endmodule

// File: rtl/mod16_seq_checker.sv
// Sequence checker top for a MOD-16 counter: SYNC/LOCK/ERR FSM, wrap counter, sticky error.
// Optional feature: define SEQ_CHECK_ERR_CNT_EN to add the saturating err_cnt output.
module mod16_seq_checker
  import mod16_seq_checker_pkg::*;
#(
  parameter int WRAP_W   = 8,
  parameter int RESYNC_N = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  count,
  input  logic              count_vld,
  input  logic              clr_err,
  output logic              locked,
  output logic              tc_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              seq_err
`ifdef SEQ_CHECK_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int RS_W = $clog2(RESYNC_N + 1);

  state_t          state;
  logic [RS_W-1:0] resync_cnt;
  logic            match;
  logic            wrap;
  logic            mismatch;

  mod16_wrap_detect u_wrap_detect (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .count_vld (count_vld),
    .match     (match),
    .wrap      (wrap)
  );

  // A checked sample (LOCK or ERR) that is not the expected increment.
  always_comb begin
    mismatch = count_vld && (state != SYNC) && !match;
  end

  // FSM with registered outputs; locked is written alongside every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SYNC;
      locked     <= 1'b0;
      tc_pulse   <= 1'b0;
      wrap_cnt   <= '0;
      seq_err    <= 1'b0;
      resync_cnt <= '0;
    end else begin
      tc_pulse <= 1'b0;
      // Clear first so that a same-cycle mismatch set below takes priority.
      if (clr_err && (state != ERR)) begin
        seq_err <= 1'b0;
      end
      if (count_vld) begin
        unique case (state)
          SYNC: begin
            state  <= LOCK;
            locked <= 1'b1;
          end
          LOCK: begin
            if (match) begin
              if (wrap) begin
                tc_pulse <= 1'b1;
                wrap_cnt <= wrap_cnt + 1'b1;
              end
            end else begin
              state      <= ERR;
              locked     <= 1'b0;
              seq_err    <= 1'b1;
              resync_cnt <= '0;
            end
          end
          ERR: begin
            if (match) begin
              if (resync_cnt == RS_W'(RESYNC_N - 1)) begin
                state      <= LOCK;
                locked     <= 1'b1;
                resync_cnt <= '0;
              end else begin
                resync_cnt <= resync_cnt + 1'b1;
              end
            end else begin
              resync_cnt <= '0;
            end
          end
          default: begin
            state  <= SYNC;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SEQ_CHECK_ERR_CNT_EN
  // Saturating count of every mismatch seen in LOCK or ERR; reset-only clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (mismatch && (err_cnt != 8'(ERR_CNT_MAX))) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mod16_seq_checker.sv
// Self-checking bench for mod16_seq_checker against a behavioural model.
// Two instances share inputs: WRAP_W=8 (main) and WRAP_W=2 (wrap-width check).
module tb_mod16_seq_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] count = '0;
  logic       count_vld = 1'b0;
  logic       clr_err = 1'b0;

  logic       locked, tc_pulse, seq_err;
  logic [7:0] wrap_cnt;
  logic       locked2, tc2, seq_err2;
  logic [1:0] wrap2;
`ifdef SEQ_CHECK_ERR_CNT_EN
  logic [7:0] err_cnt, err_cnt2;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_seen, m_in_err, m_tc, m_err;
  int m_prev, m_run, m_wraps, m_errs;

  always #5 clk = ~clk;

  mod16_seq_checker #(.WRAP_W(8), .RESYNC_N(2)) dut (
    .clk(clk), .reset(reset), .count(count), .count_vld(count_vld), .clr_err(clr_err),
    .locked(locked), .tc_pulse(tc_pulse), .wrap_cnt(wrap_cnt), .seq_err(seq_err)
`ifdef SEQ_CHECK_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  mod16_seq_checker #(.WRAP_W(2), .RESYNC_N(2)) dut2 (
    .clk(clk), .reset(reset), .count(count), .count_vld(count_vld), .clr_err(clr_err),
    .locked(locked2), .tc_pulse(tc2), .wrap_cnt(wrap2), .seq_err(seq_err2)
`ifdef SEQ_CHECK_ERR_CNT_EN
    , .err_cnt(err_cnt2)
`endif
  );

  task automatic model_reset();
    m_seen = 0; m_in_err = 0; m_tc = 0; m_err = 0;
    m_prev = 0; m_run = 0; m_wraps = 0; m_errs = 0;
  endtask

  // One clock edge of the rules: clear check uses the pre-edge mode.
  task automatic model_step(input bit vld, input int c, input bit clr);
    bit ok;
    m_tc = 0;
    if (clr && !m_in_err) m_err = 0;
    if (!vld) return;
    if (!m_seen) begin
      m_seen = 1;
    end else begin
      ok = (c == (m_prev + 1) % 16);
      if (!ok) m_errs++;
      if (!m_in_err) begin
        if (ok && c == 0) begin m_tc = 1; m_wraps++; end
        if (!ok) begin m_in_err = 1; m_err = 1; m_run = 0; end
      end else if (ok) begin
        m_run++;
        if (m_run == 2) begin m_in_err = 0; m_run = 0; end
      end else begin
        m_run = 0;
      end
    end
    m_prev = c;
  endtask

  function automatic bit m_locked();
    return m_seen && !m_in_err;
  endfunction

  task automatic drive(input bit vld, input logic [3:0] c, input bit clr);
    count = c; count_vld = vld; clr_err = clr;
    @(posedge clk);
    model_step(vld, int'(c), clr);
    #1;
    count_vld = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    #2;
    checks += 4;
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
    if (tc_pulse !== 1'b0) begin errors++; $display("FAIL reset_tc: got %b expected 0", tc_pulse); end
    if (wrap_cnt !== 8'd0) begin errors++; $display("FAIL reset_wrap: got %0d expected 0", wrap_cnt); end
    if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", seq_err); end
`ifdef SEQ_CHECK_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_errcnt: got %0d expected 0", err_cnt); end
`endif
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_count_up();
    int tcs = 0;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 4'(i % 16), 1'b0);
      if (tc_pulse === 1'b1) tcs++;
      checks += 2;
      if (locked !== m_locked()) begin errors++; $display("FAIL up_locked[%0d]: got %b expected %b", i, locked, m_locked()); end
      if (tc_pulse !== m_tc) begin errors++; $display("FAIL up_tc[%0d]: got %b expected %b", i, tc_pulse, m_tc); end
    end
    checks += 4;
    if (tcs != 1) begin errors++; $display("FAIL up_tc_count: got %0d expected 1", tcs); end
    if (wrap_cnt !== 8'd1) begin errors++; $display("FAIL up_wrap: got %0d expected 1", wrap_cnt); end
    if (locked !== 1'b1) begin errors++; $display("FAIL up_locked_end: got %b expected 1", locked); end
    if (seq_err !== 1'b0) begin errors++; $display("FAIL up_err: got %b expected 0", seq_err); end
  endtask

  task automatic test_mismatch();
    do_reset();
    drive(1'b1, 4'd4, 1'b0);
    drive(1'b1, 4'd5, 1'b0);
    drive(1'b1, 4'd6, 1'b0);
    checks += 2;
    if (locked !== 1'b1) begin errors++; $display("FAIL mm_locked_pre: got %b expected 1", locked); end
    if (seq_err !== 1'b0) begin errors++; $display("FAIL mm_err_pre: got %b expected 0", seq_err); end
    drive(1'b1, 4'd9, 1'b0);
    checks += 2;
    if (locked !== 1'b0) begin errors++; $display("FAIL mm_locked: got %b expected 0", locked); end
    if (seq_err !== 1'b1) begin errors++; $display("FAIL mm_err: got %b expected 1", seq_err); end
`ifdef SEQ_CHECK_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd1) begin errors++; $display("FAIL mm_errcnt: got %0d expected 1", err_cnt); end
`endif
  endtask

  // Continues from ERR with prev=9; clr_err during ERR must be ignored.
  task automatic test_resync();
    drive(1'b1, 4'd9, 1'b1);
    checks += 2;
    if (locked !== 1'b0) begin errors++; $display("FAIL rs_locked9: got %b expected 0", locked); end
    if (seq_err !== 1'b1) begin errors++; $display("FAIL rs_clr_in_err: got %b expected 1", seq_err); end
    drive(1'b1, 4'd10, 1'b0);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL rs_locked10: got %b expected 0", locked); end
    drive(1'b1, 4'd11, 1'b0);
    checks += 2;
    if (locked !== 1'b1) begin errors++; $display("FAIL rs_locked11: got %b expected 1", locked); end
    if (seq_err !== 1'b1) begin errors++; $display("FAIL rs_err_sticky: got %b expected 1", seq_err); end
`ifdef SEQ_CHECK_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'(m_errs)) begin errors++; $display("FAIL rs_errcnt: got %0d expected %0d", err_cnt, m_errs); end
`endif
  endtask

  // In LOCK with seq_err=1: clr_err with a mismatch keeps it set; later a lone clr clears.
  task automatic test_clr_vs_set();
    drive(1'b1, 4'd13, 1'b1);
    checks += 2;
    if (seq_err !== 1'b1) begin errors++; $display("FAIL cs_set_wins: got %b expected 1", seq_err); end
    if (locked !== 1'b0) begin errors++; $display("FAIL cs_locked: got %b expected 0", locked); end
    drive(1'b1, 4'd14, 1'b0);
    drive(1'b1, 4'd15, 1'b0);
    checks += 2;
    if (locked !== 1'b1) begin errors++; $display("FAIL cs_relock: got %b expected 1", locked); end
    if (seq_err !== 1'b1) begin errors++; $display("FAIL cs_err_hold: got %b expected 1", seq_err); end
    drive(1'b0, 4'd0, 1'b1);
    checks++;
    if (seq_err !== 1'b0) begin errors++; $display("FAIL cs_cleared: got %b expected 0", seq_err); end
  endtask

  task automatic test_gap();
    do_reset();
    drive(1'b1, 4'd14, 1'b0);
    drive(1'b1, 4'd15, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'(i + 7), 1'b0);
      checks++;
      if (tc_pulse !== 1'b0) begin errors++; $display("FAIL gap_tc[%0d]: got %b expected 0", i, tc_pulse); end
    end
    drive(1'b1, 4'd0, 1'b0);
    checks += 3;
    if (tc_pulse !== 1'b1) begin errors++; $display("FAIL gap_tc_wrap: got %b expected 1", tc_pulse); end
    if (seq_err !== 1'b0) begin errors++; $display("FAIL gap_err: got %b expected 0", seq_err); end
    if (wrap_cnt !== 8'd1) begin errors++; $display("FAIL gap_wrap: got %0d expected 1", wrap_cnt); end
    drive(1'b0, 4'd0, 1'b0);
    checks++;
    if (tc_pulse !== 1'b0) begin errors++; $display("FAIL gap_tc_once: got %b expected 0", tc_pulse); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    drive(1'b1, 4'd14, 1'b0);
    drive(1'b1, 4'd15, 1'b0);
    count = 4'd0; count_vld = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    checks += 3;
    if (locked !== 1'b0) begin errors++; $display("FAIL ra_locked_async: got %b expected 0", locked); end
    if (wrap_cnt !== 8'd0) begin errors++; $display("FAIL ra_wrap: got %0d expected 0", wrap_cnt); end
    if (seq_err !== 1'b0) begin errors++; $display("FAIL ra_err: got %b expected 0", seq_err); end
    @(posedge clk);
    #1;
    checks += 2;
    if (tc_pulse !== 1'b0) begin errors++; $display("FAIL ra_tc: got %b expected 0", tc_pulse); end
    if (locked !== 1'b0) begin errors++; $display("FAIL ra_locked_edge: got %b expected 0", locked); end
    reset = 1'b0; count_vld = 1'b0;
    // First sample after reset is a SYNC sample: locks but cannot wrap.
    drive(1'b1, 4'd0, 1'b0);
    checks += 2;
    if (tc_pulse !== 1'b0) begin errors++; $display("FAIL ra_sync_tc: got %b expected 0", tc_pulse); end
    if (locked !== 1'b1) begin errors++; $display("FAIL ra_sync_lock: got %b expected 1", locked); end
  endtask

  task automatic test_wrap_small();
    int exp_seq[5] = '{1, 2, 3, 0, 1};
    do_reset();
    drive(1'b1, 4'd0, 1'b0);
    for (int w = 0; w < 5; w++) begin
      for (int v = 1; v < 16; v++) drive(1'b1, 4'(v), 1'b0);
      drive(1'b1, 4'd0, 1'b0);
      checks += 3;
      if (tc2 !== 1'b1) begin errors++; $display("FAIL ws_tc[%0d]: got %b expected 1", w, tc2); end
      if (wrap2 !== 2'(exp_seq[w])) begin errors++; $display("FAIL ws_wrap[%0d]: got %0d expected %0d", w, wrap2, exp_seq[w]); end
      if (wrap_cnt !== 8'(w + 1)) begin errors++; $display("FAIL ws_wrap8[%0d]: got %0d expected %0d", w, wrap_cnt, w + 1); end
    end
  endtask

  task automatic test_random();
    bit vld, clr;
    int c;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      vld = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 19) == 0);
      c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : (m_prev + 1) % 16;
      drive(vld, 4'(c), clr);
      checks += 6;
      if (locked !== m_locked()) begin errors++; $display("FAIL rnd_locked[%0d]: got %b expected %b", i, locked, m_locked()); end
      if (tc_pulse !== m_tc) begin errors++; $display("FAIL rnd_tc[%0d]: got %b expected %b", i, tc_pulse, m_tc); end
      if (wrap_cnt !== 8'(m_wraps)) begin errors++; $display("FAIL rnd_wrap[%0d]: got %0d expected %0d", i, wrap_cnt, m_wraps % 256); end
      if (seq_err !== m_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", i, seq_err, m_err); end
      if (wrap2 !== 2'(m_wraps)) begin errors++; $display("FAIL rnd_wrap2[%0d]: got %0d expected %0d", i, wrap2, m_wraps % 4); end
      if (locked2 !== m_locked()) begin errors++; $display("FAIL rnd_locked2[%0d]: got %b expected %b", i, locked2, m_locked()); end
`ifdef SEQ_CHECK_ERR_CNT_EN
      checks++;
      if (err_cnt !== 8'((m_errs > 255) ? 255 : m_errs)) begin
        errors++; $display("FAIL rnd_errcnt[%0d]: got %0d expected %0d", i, err_cnt, (m_errs > 255) ? 255 : m_errs);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count_up();
    test_mismatch();
    test_resync();
    test_clr_vs_set();
    test_gap();
    test_reset_abort();
    test_wrap_small();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
